// File: rtl/exp3_gravador_sequencia.sv
// Sequence recorder: writes one chaves value per jogada rising edge into
// consecutive RAM positions 0..N_POS-1, then raises pronto.
//
// Ports:
//   clock, reset       clock and synchronous active-high reset
//   iniciar            start (or restart) a recording pass
//   jogada, chaves     record button level and value to record
//   mem_we             one-cycle RAM write enable per recorded position
//   mem_endereco       RAM address (current position counter)
//   mem_dado           RAM write data (registered chaves)
//   gravando, pronto   recording in progress / full sequence written
//   db_estado          state code for the display
//   db_jogada          copy of jogada for the display
module exp3_gravador_sequencia #(
  parameter int N_POS  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic [DATA_W-1:0] chaves,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_dado,
  output logic              gravando,
  output logic              pronto,
  output logic [3:0]        db_estado,
  output logic              db_jogada
);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    ESPERA     = 4'h2,
    GRAVA      = 4'h4,
    PROXIMO    = 4'h5,
    FIM        = 4'hF
  } estado_t;

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_POS - 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] cont_q, cont_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic              jog_prev_q;
  logic              borda;

  // Rising edge of the button level; a held button gives one edge only.
  assign borda = jogada & ~jog_prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= INICIAL;
      cont_q     <= '0;
      dado_q     <= '0;
      jog_prev_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cont_q     <= cont_d;
      dado_q     <= dado_d;
      jog_prev_q <= jogada;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    dado_d   = dado_q;
    unique case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        cont_d   = '0;
        dado_d   = '0;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (borda) begin
          dado_d   = chaves;
          estado_d = GRAVA;
        end
      end
      GRAVA: begin
        estado_d = PROXIMO;
      end
      PROXIMO: begin
        // Counter stops at the last position; it never wraps.
        if (cont_q == ULTIMO) begin
          estado_d = FIM;
        end else begin
          cont_d   = cont_q + 1'b1;
          estado_d = ESPERA;
        end
      end
      FIM: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  assign mem_we       = (estado_q == GRAVA);
  assign mem_endereco = cont_q;
  assign mem_dado     = dado_q;
  assign gravando     = (estado_q == PREPARACAO) ||
                        (estado_q == ESPERA) ||
                        (estado_q == GRAVA) ||
                        (estado_q == PROXIMO);
  assign pronto       = (estado_q == FIM);
  assign db_estado    = estado_q;
  assign db_jogada    = jogada;

endmodule
